fpc_issue_controller: RTL and testbench

//  Sequential successor to the combinational FP-coprocessor decoder.
//  - Accepts one COP1 instruction at a time over a valid/ready handshake and decodes it.
//  - Sequences the FPU via a start/done handshake with variable latency.
//  - Issues single-cycle write-back strobes for FPRs, GPR (MFC1) or one of NUM_CC condition codes.
//  - Sits between the MIPS core's issue stage and the FPU/FP register file.

---
 rtl/fpc_pkg.sv | 56 +++++
 rtl/fpc_issue_controller_decode.sv | 50 +++++
 rtl/fpc_issue_controller.sv | 138 +++++++++++++
 tb/tb_fpc_issue_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpc_pkg.sv
// ----------------------------------------------------------------------------
// fpc_pkg
// Shared definitions for the FP-coprocessor issue controller.
//   - COP1 fp_opcode / funct constants
//   - FPU operation encodings presented on fpu_op
//   - controller state constants (IDLE, EXEC, WB)
//   - decoded instruction class enum
// ----------------------------------------------------------------------------
package fpc_pkg;

    // fp_opcode field values
    localparam logic [4:0] OPC_MFC1   = 5'h00;
    localparam logic [4:0] OPC_MTC1   = 5'h04;
    localparam logic [4:0] OPC_COP1_S = 5'h10;

    // funct field values under COP1_S
    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_SUB  = 6'd1;
    localparam logic [5:0] FN_MOV  = 6'd6;
    localparam logic [5:0] FN_C_GE = 6'd40;
    localparam logic [5:0] FN_C_GT = 6'd42;
    localparam logic [5:0] FN_C_EQ = 6'd50;
    localparam logic [5:0] FN_C_LT = 6'd60;
    localparam logic [5:0] FN_C_LE = 6'd62;

    // FPU operation encodings
    localparam logic [2:0] FPU_ADD = 3'd0;
    localparam logic [2:0] FPU_SUB = 3'd1;
    localparam logic [2:0] FPU_EQ  = 3'd2;
    localparam logic [2:0] FPU_LT  = 3'd3;
    localparam logic [2:0] FPU_GT  = 3'd4;
    localparam logic [2:0] FPU_LE  = 3'd5;
    localparam logic [2:0] FPU_GE  = 3'd6;
    localparam logic [2:0] FPU_MOV = 3'd7;

    // Controller state
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_WB   = 2'd2;

    // Decoded instruction class
    typedef enum logic [2:0] {
        CLS_FPU_REG,
        CLS_FPU_CC,
        CLS_MTC1,
        CLS_MFC1,
        CLS_BAD
    } cls_e;

    // True for classes that need an FPU start/done exchange
    function automatic logic cls_uses_fpu(input cls_e c);
        return (c == CLS_FPU_REG) || (c == CLS_FPU_CC);
    endfunction

endpackage

// File: rtl/fpc_issue_controller_decode.sv
// ----------------------------------------------------------------------------
// fpc_funct_decode
// Purely combinational decode of a COP1 instruction into its class and the
// FPU operation it needs. Anything not recognised decodes to CLS_BAD with
// fpu_op = 0; non-FPU classes also report fpu_op = 0.
// Ports:
//   fp_opcode  in   5     COP1 fmt/rs field
//   funct      in   6     function field (meaningful under COP1_S)
//   cls        out  cls_e decoded class
//   fpu_op     out  OP_W  FPU operation for FPU classes
// ----------------------------------------------------------------------------
module fpc_funct_decode
    import fpc_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic [4:0]      fp_opcode,
    input  logic [5:0]      funct,
    output cls_e            cls,
    output logic [OP_W-1:0] fpu_op
);

    logic [2:0] op3;

    always_comb begin
        cls = CLS_BAD;
        op3 = FPU_ADD;
        case (fp_opcode)
            OPC_MFC1: cls = CLS_MFC1;
            OPC_MTC1: cls = CLS_MTC1;
            OPC_COP1_S: begin
                case (funct)
                    FN_ADD:  begin cls = CLS_FPU_REG; op3 = FPU_ADD; end
                    FN_SUB:  begin cls = CLS_FPU_REG; op3 = FPU_SUB; end
                    FN_MOV:  begin cls = CLS_FPU_REG; op3 = FPU_MOV; end
                    FN_C_EQ: begin cls = CLS_FPU_CC;  op3 = FPU_EQ;  end
                    FN_C_LT: begin cls = CLS_FPU_CC;  op3 = FPU_LT;  end
                    FN_C_GT: begin cls = CLS_FPU_CC;  op3 = FPU_GT;  end
                    FN_C_LE: begin cls = CLS_FPU_CC;  op3 = FPU_LE;  end
                    FN_C_GE: begin cls = CLS_FPU_CC;  op3 = FPU_GE;  end
                    default: begin cls = CLS_BAD;     op3 = FPU_ADD; end
                endcase
            end
            default: cls = CLS_BAD;
        endcase
    end

    assign fpu_op = OP_W'(op3);

endmodule

// File: rtl/fpc_issue_controller.sv
// ----------------------------------------------------------------------------
// fpc_issue_controller
// Sequential FP-coprocessor issue controller. Accepts one COP1 instruction
// at a time over valid/ready, sequences the FPU with start/done and issues a
// single-cycle write-back strobe (FPR, GPR or condition code).
//
// Build option: macro FPC_ILLEGAL_TRAP_EN
//   defined   - unknown instructions pulse 'illegal' in their WB cycle
//   undefined - unknown instructions are a silent one-cycle NOP, illegal = 0
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   instr_valid    in   instruction presented
//   instr_ready    out  controller idle and able to accept
//   fp_opcode      in   5  MFC1 / MTC1 / COP1_S
//   funct          in   6  operation under COP1_S
//   fd             in   FPR_AW destination FPR (source FPR for MFC1)
//   cc_idx         in   CC_W condition-code target for compares
//   fpu_start      out  one-cycle FPU start pulse
//   fpu_op         out  OP_W FPU operation, stable while busy
//   fpu_done       in   FPU completion (observed only in EXEC)
//   flush          in   abort of the in-flight instruction
//   reg_wr_en      out  FPR write strobe
//   gpr_wr_en      out  GPR write strobe (MFC1)
//   cc_wr_en       out  condition-code write strobe
//   wr_addr        out  FPR_AW latched fd
//   cc_sel         out  CC_W latched cc_idx
//   wb_src         out  0 = FPU result, 1 = processor data (MTC1)
//   illegal        out  illegal-instruction pulse
//   busy           out  inverse of instr_ready
// ----------------------------------------------------------------------------
module fpc_issue_controller
    import fpc_pkg::*;
#(
    parameter int FPR_AW = 5,
    parameter int NUM_CC = 8,
    parameter int OP_W   = 3,
    parameter int CC_W   = (NUM_CC > 1) ? $clog2(NUM_CC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        fp_opcode,
    input  logic [5:0]        funct,
    input  logic [FPR_AW-1:0] fd,
    input  logic [CC_W-1:0]   cc_idx,
    output logic              fpu_start,
    output logic [OP_W-1:0]   fpu_op,
    input  logic              fpu_done,
    input  logic              flush,
    output logic              reg_wr_en,
    output logic              gpr_wr_en,
    output logic              cc_wr_en,
    output logic [FPR_AW-1:0] wr_addr,
    output logic [CC_W-1:0]   cc_sel,
    output logic              wb_src,
    output logic              illegal,
    output logic              busy
);

    state_t          state;
    cls_e            cls_q;
    logic            start_pend;
    cls_e            dec_cls;
    logic [OP_W-1:0] dec_op;
    logic            accept;
    logic            wb_live;

    fpc_funct_decode #(.OP_W(OP_W)) u_decode (
        .fp_opcode (fp_opcode),
        .funct     (funct),
        .cls       (dec_cls),
        .fpu_op    (dec_op)
    );

    assign instr_ready = (state == ST_IDLE);
    assign busy        = ~instr_ready;
    assign accept      = instr_valid & instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cls_q      <= CLS_BAD;
            start_pend <= 1'b0;
            fpu_op     <= '0;
            wr_addr    <= '0;
            cc_sel     <= '0;
            wb_src     <= 1'b0;
        end else begin
            // start_pend is high for exactly the first EXEC cycle
            start_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // flush is deliberately not looked at here
                    if (accept) begin
                        cls_q   <= dec_cls;
                        fpu_op  <= dec_op;
                        wr_addr <= fd;
                        cc_sel  <= cc_idx;
                        wb_src  <= (dec_cls == CLS_MTC1);
                        if (cls_uses_fpu(dec_cls)) begin
                            state      <= ST_EXEC;
                            start_pend <= 1'b1;
                        end else begin
                            state <= ST_WB;
                        end
                    end
                end
                ST_EXEC: begin
                    // flush wins over a coincident fpu_done
                    if (flush) begin
                        state <= ST_IDLE;
                    end else if (fpu_done) begin
                        state <= ST_WB;
                    end
                end
                ST_WB:   state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fpu_start = start_pend;

    // A flush arriving in the WB cycle itself cancels the write
    assign wb_live   = (state == ST_WB) && !flush;
    assign reg_wr_en = wb_live && ((cls_q == CLS_FPU_REG) || (cls_q == CLS_MTC1));
    assign cc_wr_en  = wb_live && (cls_q == CLS_FPU_CC);
    assign gpr_wr_en = wb_live && (cls_q == CLS_MFC1);

`ifdef FPC_ILLEGAL_TRAP_EN
    assign illegal = (state == ST_WB) && (cls_q == CLS_BAD);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fpc_issue_controller.sv
`timescale 1ns/1ps
module tb_fpc_issue_controller;

    localparam int FPR_AW = 5;
    localparam int NUM_CC = 8;
    localparam int OP_W   = 3;
    localparam int CC_W   = 3;

    // Instruction encodings as seen from the core side
    localparam logic [4:0] T_MFC1 = 5'h00;
    localparam logic [4:0] T_MTC1 = 5'h04;
    localparam logic [4:0] T_COP1 = 5'h10;

    localparam int K_REG = 0, K_CC = 1, K_MTC1 = 2, K_MFC1 = 3, K_BAD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [4:0]        fp_opcode;
    logic [5:0]        funct;
    logic [FPR_AW-1:0] fd;
    logic [CC_W-1:0]   cc_idx;
    logic              fpu_start;
    logic [OP_W-1:0]   fpu_op;
    logic              fpu_done;
    logic              flush;
    logic              reg_wr_en;
    logic              gpr_wr_en;
    logic              cc_wr_en;
    logic [FPR_AW-1:0] wr_addr;
    logic [CC_W-1:0]   cc_sel;
    logic              wb_src;
    logic              illegal;
    logic              busy;

    fpc_issue_controller #(
        .FPR_AW(FPR_AW), .NUM_CC(NUM_CC), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .fp_opcode(fp_opcode), .funct(funct), .fd(fd), .cc_idx(cc_idx),
        .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_done(fpu_done), .flush(flush),
        .reg_wr_en(reg_wr_en), .gpr_wr_en(gpr_wr_en), .cc_wr_en(cc_wr_en),
        .wr_addr(wr_addr), .cc_sel(cc_sel), .wb_src(wb_src),
        .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int cyc;
        bit rw;
        bit gw;
        bit cw;
        bit il;
        int addr;
        int ccs;
        bit src;
    } wb_t;

    typedef struct {
        int cyc;
        int op;
    } st_t;

    wb_t wbq[$];
    st_t stq[$];
    wb_t me;
    st_t ms;

    int checks = 0;
    int failures = 0;
    int exp_ready_cyc = 0;
    bit mon_en = 0;

    logic [5:0] ftab [8] = '{6'd0, 6'd1, 6'd6, 6'd40, 6'd42, 6'd50, 6'd60, 6'd62};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference classification straight from the instruction table
    function automatic int classify(input logic [4:0] opc, input logic [5:0] fn);
        if (opc == T_MTC1) return K_MTC1;
        if (opc == T_MFC1) return K_MFC1;
        if (opc == T_COP1) begin
            if (fn inside {6'd0, 6'd1, 6'd6}) return K_REG;
            if (fn inside {6'd40, 6'd42, 6'd50, 6'd60, 6'd62}) return K_CC;
        end
        return K_BAD;
    endfunction

    function automatic int exp_op(input logic [5:0] fn);
        case (fn)
            6'd0:    return 0;
            6'd1:    return 1;
            6'd50:   return 2;
            6'd60:   return 3;
            6'd42:   return 4;
            6'd62:   return 5;
            6'd40:   return 6;
            6'd6:    return 7;
            default: return -1;
        endcase
    endfunction

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("instr_ready", int'(instr_ready), int'(cyc >= exp_ready_cyc));
            check("busy", int'(busy), int'(cyc < exp_ready_cyc));
            while (wbq.size() > 0 && wbq[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL wb_missing: got no strobe expected one at cycle %0d", wbq[0].cyc);
                void'(wbq.pop_front());
            end
            while (stq.size() > 0 && stq[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL start_missing: got no fpu_start expected one at cycle %0d", stq[0].cyc);
                void'(stq.pop_front());
            end
            if (reg_wr_en || gpr_wr_en || cc_wr_en || illegal) begin
                if (wbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL wb_unexpected: got r%0b g%0b c%0b i%0b at cycle %0d expected none",
                             reg_wr_en, gpr_wr_en, cc_wr_en, illegal, cyc);
                end else begin
                    me = wbq.pop_front();
                    check("wb_cycle", cyc, me.cyc);
                    check("reg_wr_en", int'(reg_wr_en), int'(me.rw));
                    check("gpr_wr_en", int'(gpr_wr_en), int'(me.gw));
                    check("cc_wr_en", int'(cc_wr_en), int'(me.cw));
                    check("illegal", int'(illegal), int'(me.il));
                    if (me.rw || me.gw) check("wr_addr", int'(wr_addr), me.addr);
                    if (me.cw) check("cc_sel", int'(cc_sel), me.ccs);
                    if (me.rw) check("wb_src", int'(wb_src), int'(me.src));
                end
            end
            if (fpu_start) begin
                if (stq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL start_unexpected: got fpu_start at cycle %0d expected none", cyc);
                end else begin
                    ms = stq.pop_front();
                    check("start_cycle", cyc, ms.cyc);
                    check("fpu_op", int'(fpu_op), ms.op);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        instr_valid = 1'($urandom % 2);
        fp_opcode   = 5'($urandom);
        funct       = 6'($urandom);
        fd          = 5'($urandom);
        cc_idx      = 3'($urandom);
    endtask

    // Advances until the controller is idle; done/flush toggle randomly while idle
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            fpu_done = ($urandom % 4 == 0);
            flush    = ($urandom % 4 == 0);
            if (instr_ready) begin
                ok = 1;
                break;
            end
            junk();
        end
    endtask

    // d: cycles from start to fpu_done; fl: EXEC/WB cycle offset of flush (-1 none)
    task automatic issue(input logic [4:0] opc, input logic [5:0] fn, input int a,
                         input int ccv, input int d, input int fl);
        bit  ok;
        int  c, k, nxt;
        wb_t e;
        wait_ready(ok);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL ready_timeout: got instr_ready=0 for 20 cycles expected 1");
            return;
        end
        instr_valid = 1'b1;
        fp_opcode   = opc;
        funct       = fn;
        fd          = 5'(a);
        cc_idx      = 3'(ccv);
        c = cyc;
        k = classify(opc, fn);
        e = '{cyc: 0, rw: 0, gw: 0, cw: 0, il: 0, addr: a, ccs: ccv, src: 0};
        if (k == K_REG || k == K_CC) begin
            stq.push_back('{cyc: c + 1, op: exp_op(fn)});
            if (fl < 0) begin
                e.cyc = c + d + 2;
                e.rw  = (k == K_REG);
                e.cw  = (k == K_CC);
                wbq.push_back(e);
                nxt = c + d + 3;
            end else begin
                nxt = c + fl + 2;
            end
        end else begin
            e.cyc = c + 1;
            if (k == K_MTC1) begin e.rw = 1; e.src = 1; wbq.push_back(e); end
            if (k == K_MFC1) begin e.gw = 1; wbq.push_back(e); end
`ifdef FPC_ILLEGAL_TRAP_EN
            if (k == K_BAD) begin e.il = 1; wbq.push_back(e); end
`endif
            nxt = c + 2;
        end
        tick();
        exp_ready_cyc = nxt;
        if (k == K_REG || k == K_CC) begin
            for (int j = 0; j <= d + 1; j++) begin
                if (j > 0) tick();
                junk();
                fpu_done = (j == d);
                flush    = (j == fl);
                if (j == fl) break;
            end
        end else begin
            junk();
            fpu_done = 1'($urandom % 2);
            flush    = 1'b0;
        end
    endtask

    task automatic reset_mid_exec();
        bit ok;
        int c;
        wait_ready(ok);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL ready_timeout: got instr_ready=0 for 20 cycles expected 1");
            return;
        end
        instr_valid = 1'b1; fp_opcode = T_COP1; funct = 6'd0; fd = 5'd9; cc_idx = 3'd0;
        c = cyc;
        stq.push_back('{cyc: c + 1, op: 0});
        tick();
        exp_ready_cyc = c + 1000;
        instr_valid = 1'b0; fpu_done = 1'b0; flush = 1'b0;
        tick();
        rst = 1'b1;
        exp_ready_cyc = cyc;
        #1;
        check("rst_mid_ready", int'(instr_ready), 1);
        check("rst_mid_fpu_start", int'(fpu_start), 0);
        check("rst_mid_wr_addr", int'(wr_addr), 0);
        tick();
        rst = 1'b0;
        tick();
        fpu_done = 1'b1;
        tick();
        fpu_done = 1'b0;
        check("rst_late_done_ready", int'(instr_ready), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, d, fl;
        logic [4:0] opc;
        logic [5:0] fn;
        rst = 1'b1; instr_valid = 1'b0; fp_opcode = '0; funct = '0; fd = '0;
        cc_idx = '0; fpu_done = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_ready", int'(instr_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_reg_wr_en", int'(reg_wr_en), 0);
        check("rst_gpr_wr_en", int'(gpr_wr_en), 0);
        check("rst_cc_wr_en", int'(cc_wr_en), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_fpu_start", int'(fpu_start), 0);
        check("rst_fpu_op", int'(fpu_op), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_cc_sel", int'(cc_sel), 0);
        check("rst_wb_src", int'(wb_src), 0);
        rst = 1'b0;
        exp_ready_cyc = 0;
        mon_en = 1'b1;

        issue(T_MTC1, 6'd0, 7, 0, 0, -1);
        issue(T_COP1, 6'd0, 3, 0, 3, -1);
        issue(T_COP1, 6'd60, 0, 5, 0, -1);
        issue(T_COP1, 6'd0, 4, 0, 2, 2);
        issue(T_COP1, 6'd1, 6, 0, 1, 2);
        issue(T_COP1, 6'd50, 2, 1, 4, 1);
        issue(T_MFC1, 6'd0, 12, 0, 0, -1);
        issue(T_COP1, 6'h3F, 1, 1, 0, -1);
        issue(5'h1F, 6'd0, 2, 2, 0, -1);
        issue(T_COP1, 6'd6, 31, 7, 2, -1);
        reset_mid_exec();

        for (int n = 0; n < 300; n++) begin
            r = int'($urandom % 10);
            fn = 6'($urandom);
            case (r)
                0, 1: opc = T_MTC1;
                2, 3: opc = T_MFC1;
                4: begin
                    opc = 5'($urandom);
                    while (opc == T_MFC1 || opc == T_MTC1 || opc == T_COP1) opc = 5'($urandom);
                end
                5: opc = T_COP1;
                default: begin
                    opc = T_COP1;
                    fn  = ftab[$urandom % 8];
                end
            endcase
            d  = int'($urandom % 5);
            fl = ($urandom % 4 == 0) ? int'($urandom_range(0, d + 1)) : -1;
            issue(opc, fn, int'($urandom % 32), int'($urandom % 8), d, fl);
        end

        tick();
        instr_valid = 1'b0; fpu_done = 1'b0; flush = 1'b0;
        repeat (4) tick();
        check("wbq_drained", wbq.size(), 0);
        check("stq_drained", stq.size(), 0);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
